// File: rtl/crc_feed_fifo.sv
// crc_feed_fifo: register-mapped 32-bit FIFO that feeds a CRC data register
// through a length-counted, gap-paced valid/ready stream.
`ifndef PAW
`define PAW 12
`endif

module crc_feed_fifo #(
    parameter int unsigned BASE  = 'h2A4,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned GAP   = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            edwr_l_i,
    input  logic            edwr_h_i,
    input  logic            sedrd_i,
    input  logic [`PAW-1:0] pr_adr_i,
    input  logic [31:0]     src_i,
    output logic [31:0]     pr_src_o,
    output logic            out_vld_o,
    output logic [31:0]     out_dat_o,
    input  logic            out_rdy_i,
    output logic            irq_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [2:0]    GAP_LD   = (GAP > 0) ? 3'(GAP - 1) : 3'd0;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_DONE} state_e;

    state_e        state_q, state_d;
    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [LW-1:0] level_q;
    logic [15:0]   stage_q, len_q, rem_q, rem_d;
    logic [2:0]    gcnt_q, gcnt_d;
    logic          irq_en_q, done_q, ovf_q, done_set;

    logic hit_data, hit_ctrl, hit_stat, hit_len;
    logic wr_l, wr_h, rd;
    logic ctrl_wr, start, flush, push_req, push_ok, beat;
    logic stat_rd, len_rd, full, empty, busy;
    logic [31:0] push_word, status;

    assign hit_data = (pr_adr_i == `PAW'(BASE));
    assign hit_ctrl = (pr_adr_i == `PAW'(BASE + 1));
    assign hit_stat = (pr_adr_i == `PAW'(BASE + 2));
    assign hit_len  = (pr_adr_i == `PAW'(BASE + 3));

    assign wr_l = ~edwr_l_i;
    assign wr_h = ~edwr_h_i;
    assign rd   = ~sedrd_i;

    assign full  = (level_q == FULL_LVL);
    assign empty = (level_q == '0);
    assign busy  = (state_q == S_RUN) || (state_q == S_GAP);

    assign ctrl_wr   = hit_ctrl & wr_l;
    assign start     = ctrl_wr & src_i[0];
    assign flush     = ctrl_wr & src_i[1];
    assign push_req  = hit_data & wr_h;
    assign push_ok   = push_req & ~full & ~flush;
    // High-half strobe commits the word; the low half comes from the bus
    // only when both strobes are active together.
    assign push_word = {src_i[31:16], wr_l ? src_i[15:0] : stage_q};

    assign out_vld_o = (state_q == S_RUN) & ~empty;
    assign out_dat_o = out_vld_o ? mem_q[rptr_q] : '0;
    assign beat      = out_vld_o & out_rdy_i & ~flush;

    // Reads are gated by reset so the bus stays released while rst_i is low.
    assign stat_rd  = rst_i & rd & hit_stat;
    assign len_rd   = rst_i & rd & hit_len;
    assign status   = {22'd0, busy, ovf_q, done_q, full, empty, 5'(level_q)};
    assign pr_src_o = stat_rd ? status : (len_rd ? {16'd0, rem_q} : 'z);
    assign irq_o    = done_q & irq_en_q;

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q] <= push_word;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else if (flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + AW'(1);
            if (beat)    rptr_q <= rptr_q + AW'(1);
            level_q <= level_q + LW'(push_ok) - LW'(beat);
        end
    end

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        gcnt_d   = gcnt_q;
        done_set = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                rem_d   = len_q;
                state_d = (len_q == '0) ? S_DONE : S_RUN;
            end
            S_RUN: if (beat) begin
                rem_d = rem_q - 16'd1;
                if (rem_q == 16'd1)  state_d = S_DONE;
                else if (GAP > 0) begin
                    state_d = S_GAP;
                    gcnt_d  = GAP_LD;
                end
            end
            S_GAP: begin
                if (gcnt_q == '0) state_d = S_RUN;
                else              gcnt_d  = gcnt_q - 3'd1;
            end
            S_DONE: begin
                done_set = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
            rem_d   = '0;
            gcnt_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            rem_q    <= '0;
            gcnt_q   <= '0;
            stage_q  <= '0;
            len_q    <= '0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            gcnt_q  <= gcnt_d;
            if (hit_data & wr_l & ~wr_h) stage_q  <= src_i[15:0];
            if (hit_len & wr_l)          len_q    <= src_i[15:0];
            if (ctrl_wr)                 irq_en_q <= src_i[2];
            // A new event in the same cycle as a STATUS read wins over the clear.
            if (done_set)     done_q <= 1'b1;
            else if (stat_rd) done_q <= 1'b0;
            if (push_req & full) ovf_q <= 1'b1;
            else if (stat_rd)    ovf_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_crc_feed_fifo.sv
// Scoreboard bench for crc_feed_fifo: pushed words are queued as expected
// beats and compared when the downstream handshake fires.
`ifndef PAW
`define PAW 12
`endif

module tb_crc_feed_fifo;
    localparam int unsigned BASE  = 'h2A4;
    localparam int          DEPTH = 8;
    localparam int          GAP   = 1;
    localparam logic [`PAW-1:0] A_DATA = `PAW'(BASE);
    localparam logic [`PAW-1:0] A_CTRL = `PAW'(BASE + 1);
    localparam logic [`PAW-1:0] A_STAT = `PAW'(BASE + 2);
    localparam logic [`PAW-1:0] A_LEN  = `PAW'(BASE + 3);

    logic            clk = 1'b0;
    logic            rst_i = 1'b0;
    logic            edwr_l_i = 1'b1, edwr_h_i = 1'b1, sedrd_i = 1'b1;
    logic [`PAW-1:0] pr_adr_i = '0;
    logic [31:0]     src_i = '0;
    wire  [31:0]     pr_src_o;
    logic            out_vld_o;
    logic [31:0]     out_dat_o;
    logic            out_rdy_i = 1'b0;
    logic            irq_o;

    int vectors = 0, miscompares = 0, beats = 0, cyc = 0;
    logic [31:0] exp_q[$];
    int          beat_cyc[$];

    crc_feed_fifo #(.BASE(BASE), .DEPTH(DEPTH), .GAP(GAP)) dut (
        .clk_i(clk), .rst_i(rst_i), .edwr_l_i(edwr_l_i), .edwr_h_i(edwr_h_i),
        .sedrd_i(sedrd_i), .pr_adr_i(pr_adr_i), .src_i(src_i), .pr_src_o(pr_src_o),
        .out_vld_o(out_vld_o), .out_dat_o(out_dat_o), .out_rdy_i(out_rdy_i), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    // One clock: sample the handshake just before the edge, return after it.
    task automatic tick();
        logic [31:0] exp_w;
        @(negedge clk); #4;
        if (rst_i && out_vld_o && out_rdy_i) begin
            beats++;
            beat_cyc.push_back(cyc);
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL beat_unexpected got=%h want=no beat", out_dat_o);
            end else begin
                exp_w = exp_q.pop_front();
                if (out_dat_o !== exp_w) begin
                    miscompares++;
                    $display("FAIL beat_data got=%h want=%h", out_dat_o, exp_w);
                end
            end
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic bus_wr(input logic [`PAW-1:0] a, input logic [31:0] d,
                          input logic lo, input logic hi);
        pr_adr_i = a; src_i = d; edwr_l_i = ~lo; edwr_h_i = ~hi;
        tick();
        edwr_l_i = 1'b1; edwr_h_i = 1'b1;
    endtask

    task automatic bus_rd(input logic [`PAW-1:0] a, output logic [31:0] d);
        pr_adr_i = a; sedrd_i = 1'b0;
        #1 d = pr_src_o;
        tick();
        sedrd_i = 1'b1;
    endtask

    task automatic push(input logic [31:0] w);
        bus_wr(A_DATA, w, 1'b1, 1'b1);
        if (exp_q.size() < DEPTH) exp_q.push_back(w);
    endtask

    task automatic wait_beats(input int target, output bit ok);
        for (int i = 0; i < 100; i++) begin
            if (beats >= target) break;
            tick();
        end
        ok = (beats >= target);
    endtask

    task automatic test_reset();
        logic [31:0] r;
        rst_i = 1'b0; pr_adr_i = A_STAT; sedrd_i = 1'b0;
        idle(2);
        vectors++;
        if (out_vld_o !== 1'b0 || out_dat_o !== 32'h0 || irq_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs got vld=%b dat=%h irq=%b want 0/0/0", out_vld_o, out_dat_o, irq_o);
        end
        sedrd_i = 1'b1;
        rst_i = 1'b1;
        bus_rd(A_STAT, r);
        vectors++;
        if (r !== 32'h020) begin miscompares++; $display("FAIL reset_status got=%h want=%h", r, 32'h020); end
        bus_rd(A_LEN, r);
        vectors++;
        if (r !== 32'h0) begin miscompares++; $display("FAIL reset_len got=%h want=0", r); end
    endtask

    task automatic test_basic();
        logic [31:0] r;
        bit ok;
        int b0;
        out_rdy_i = 1'b1;
        push(32'h1111_1111);
        bus_wr(A_DATA, 32'h0000_2222, 1'b1, 1'b0);
        bus_wr(A_DATA, 32'h2222_0000, 1'b0, 1'b1);
        exp_q.push_back(32'h2222_2222);
        push(32'h3333_3333);
        bus_wr(A_LEN, 32'd3, 1'b1, 1'b0);
        b0 = beats;
        beat_cyc.delete();
        bus_wr(A_CTRL, 32'h1, 1'b1, 1'b0);
        wait_beats(b0 + 3, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL basic_beats got=%0d want=%0d", beats - b0, 3); end
        vectors++;
        if (beat_cyc.size() != 3 || beat_cyc[1] - beat_cyc[0] != 2 || beat_cyc[2] - beat_cyc[1] != 2) begin
            miscompares++;
            $display("FAIL basic_spacing got n=%0d gaps=%0d,%0d want 3 beats gaps 2,2",
                     beat_cyc.size(), beat_cyc[1] - beat_cyc[0], beat_cyc[2] - beat_cyc[1]);
        end
        idle(3);
        bus_rd(A_STAT, r);
        vectors++;
        if (r !== 32'h0A0) begin miscompares++; $display("FAIL basic_status got=%h want=%h", r, 32'h0A0); end
        bus_rd(A_STAT, r);
        vectors++;
        if (r !== 32'h020) begin miscompares++; $display("FAIL basic_done_clear got=%h want=%h", r, 32'h020); end
        out_rdy_i = 1'b0;
    endtask

    task automatic test_overflow();
        logic [31:0] r;
        bit ok;
        int b0;
        out_rdy_i = 1'b0;
        for (int i = 0; i <= DEPTH; i++) push(32'hA000_0000 + i);
        bus_rd(A_STAT, r);
        vectors++;
        if (r !== 32'h148) begin miscompares++; $display("FAIL ovf_status got=%h want=%h", r, 32'h148); end
        bus_rd(A_STAT, r);
        vectors++;
        if (r !== 32'h048) begin miscompares++; $display("FAIL ovf_clear got=%h want=%h", r, 32'h048); end
        bus_wr(A_LEN, DEPTH, 1'b1, 1'b0);
        out_rdy_i = 1'b1;
        b0 = beats;
        bus_wr(A_CTRL, 32'h1, 1'b1, 1'b0);
        wait_beats(b0 + DEPTH, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL ovf_drain got=%0d want=%0d", beats - b0, DEPTH); end
        idle(3);
        bus_rd(A_STAT, r);
        vectors++;
        if (r !== 32'h0A0) begin miscompares++; $display("FAIL ovf_done got=%h want=%h", r, 32'h0A0); end
        out_rdy_i = 1'b0;
    endtask

    task automatic test_stall();
        logic [31:0] r;
        bit ok;
        int b0;
        out_rdy_i = 1'b0;
        push(32'hC0DE_0001);
        push(32'hC0DE_0002);
        bus_wr(A_LEN, 32'd2, 1'b1, 1'b0);
        b0 = beats;
        bus_wr(A_CTRL, 32'h1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            bus_rd(A_LEN, r);
            vectors++;
            if (r !== 32'd2 || out_vld_o !== 1'b1 || out_dat_o !== 32'hC0DE_0001 || beats != b0) begin
                miscompares++;
                $display("FAIL stall_hold got rem=%h vld=%b dat=%h beats=%0d want 2/1/c0de0001/%0d",
                         r, out_vld_o, out_dat_o, beats, b0);
            end
        end
        out_rdy_i = 1'b1;
        wait_beats(b0 + 2, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL stall_release got=%0d want=2", beats - b0); end
        idle(3);
        bus_rd(A_STAT, r);
        vectors++;
        if (r !== 32'h0A0) begin miscompares++; $display("FAIL stall_done got=%h want=%h", r, 32'h0A0); end
        out_rdy_i = 1'b0;
    endtask

    task automatic test_len0_irq();
        logic [31:0] r;
        int b0;
        bus_wr(A_LEN, 32'd0, 1'b1, 1'b0);
        b0 = beats;
        bus_wr(A_CTRL, 32'h5, 1'b1, 1'b0);
        idle(1);
        vectors++;
        if (irq_o !== 1'b1) begin miscompares++; $display("FAIL len0_irq got=%b want=1", irq_o); end
        idle(3);
        vectors++;
        if (irq_o !== 1'b1 || beats != b0) begin
            miscompares++;
            $display("FAIL len0_hold got irq=%b beats=%0d want 1/0", irq_o, beats - b0);
        end
        bus_rd(A_STAT, r);
        vectors++;
        if (r !== 32'h0A0) begin miscompares++; $display("FAIL len0_status got=%h want=%h", r, 32'h0A0); end
        vectors++;
        if (irq_o !== 1'b0) begin miscompares++; $display("FAIL len0_irq_clear got=%b want=0", irq_o); end
        bus_wr(A_CTRL, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_flush();
        logic [31:0] r;
        int b0;
        out_rdy_i = 1'b0;
        for (int i = 0; i < 4; i++) push(32'hF100_0000 + i);
        bus_wr(A_LEN, 32'd4, 1'b1, 1'b0);
        bus_wr(A_CTRL, 32'h1, 1'b1, 1'b0);
        idle(2);
        vectors++;
        if (out_vld_o !== 1'b1) begin miscompares++; $display("FAIL flush_pre_vld got=%b want=1", out_vld_o); end
        bus_wr(A_CTRL, 32'h2, 1'b1, 1'b0);
        exp_q.delete();
        vectors++;
        if (out_vld_o !== 1'b0) begin miscompares++; $display("FAIL flush_vld got=%b want=0", out_vld_o); end
        bus_rd(A_STAT, r);
        vectors++;
        if (r !== 32'h020) begin miscompares++; $display("FAIL flush_status got=%h want=%h", r, 32'h020); end
        bus_rd(A_LEN, r);
        vectors++;
        if (r !== 32'h0) begin miscompares++; $display("FAIL flush_rem got=%h want=0", r); end
        out_rdy_i = 1'b1;
        b0 = beats;
        idle(5);
        vectors++;
        if (beats != b0) begin miscompares++; $display("FAIL flush_no_beats got=%0d want=0", beats - b0); end
        out_rdy_i = 1'b0;
    endtask

    task automatic test_reset_gap();
        logic [31:0] r;
        bit ok;
        int b0;
        out_rdy_i = 1'b1;
        for (int i = 0; i < 3; i++) push(32'h6A90_0000 + i);
        bus_wr(A_LEN, 32'd3, 1'b1, 1'b0);
        b0 = beats;
        bus_wr(A_CTRL, 32'h1, 1'b1, 1'b0);
        wait_beats(b0 + 1, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL rgap_first got=%0d want=1", beats - b0); end
        rst_i = 1'b0;
        #1;
        vectors++;
        if (out_vld_o !== 1'b0 || out_dat_o !== 32'h0 || irq_o !== 1'b0) begin
            miscompares++;
            $display("FAIL rgap_outputs got vld=%b dat=%h irq=%b want 0/0/0", out_vld_o, out_dat_o, irq_o);
        end
        idle(2);
        exp_q.delete();
        rst_i = 1'b1;
        bus_rd(A_STAT, r);
        vectors++;
        if (r !== 32'h020) begin miscompares++; $display("FAIL rgap_status got=%h want=%h", r, 32'h020); end
        push(32'h5A5A_A5A5);
        bus_wr(A_LEN, 32'd1, 1'b1, 1'b0);
        b0 = beats;
        bus_wr(A_CTRL, 32'h1, 1'b1, 1'b0);
        idle(8);
        vectors++;
        if (beats != b0 + 1) begin miscompares++; $display("FAIL rgap_one_beat got=%0d want=1", beats - b0); end
        bus_rd(A_STAT, r);
        vectors++;
        if (r !== 32'h0A0) begin miscompares++; $display("FAIL rgap_done got=%h want=%h", r, 32'h0A0); end
        out_rdy_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_stall();
        test_len0_irq();
        test_flush();
        test_reset_gap();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/crc_feed_fifo.md
CRC_FEED_FIFO -- requirements
Module: crc_feed_fifo

Interface
REQ-001 SHALL have parameter BASE, default 'h2A4, meaning the peripheral base address of its four-register window.
REQ-002 SHALL have parameter DEPTH, default 8, meaning the FIFO depth in 32-bit words (power of two, 2..16).
REQ-003 SHALL have parameter GAP, default 1, meaning the minimum idle cycles after each downstream beat (0..7), giving the CRC stage time to fold each word.
REQ-004 SHALL have port clk_i, input, 1, the clock.
REQ-005 SHALL have port rst_i, input, 1, the asynchronous active-low reset.
REQ-006 SHALL have port edwr_l_i, input, 1, the active-low write strobe for bits 15:0.
REQ-007 SHALL have port edwr_h_i, input, 1, the active-low write strobe for bits 31:16.
REQ-008 SHALL have port sedrd_i, input, 1, the active-low read strobe.
REQ-009 SHALL have port pr_adr_i, input, `PAW, the peripheral address.
REQ-010 SHALL have port src_i, input, 32, the write data.
REQ-011 SHALL have port pr_src_o, output, 32, the read data, driven only during a matching read and high-Z otherwise.
REQ-012 SHALL have port out_vld_o, output, 1, meaning the downstream word is valid.
REQ-013 SHALL have port out_dat_o, output, 32, the downstream word to the CRC data register.
REQ-014 SHALL have port out_rdy_i, input, 1, meaning downstream accepts.
REQ-015 SHALL have port irq_o, output, 1, the level interrupt for done.

Function
REQ-016 SHALL decode BASE+0 as DATA (write-only FIFO push), BASE+1 as CTRL (write), BASE+2 as STATUS (read) and BASE+3 as LEN (write: length[15:0]; read: remaining[15:0]).
REQ-017 SHALL handle DATA writes as follows: edwr_l_i low alone updates a 16-bit staging low half; edwr_h_i low pushes {src_i[31:16], src_i[15:0] if edwr_l_i also low else staged low}.
REQ-018 SHALL drop a push when the FIFO is full and set sticky ovf, even if a pop occurs in the same cycle.
REQ-019 SHALL apply CTRL writes only when edwr_l_i is low: bit0 start (self-clearing), bit1 flush (self-clearing), bit2 irq_en (held).
REQ-020 SHALL format STATUS as [4:0] level, [5] empty, [6] full, [7] done, [8] ovf, [9] busy, [31:10] zero.
REQ-021 SHALL clear done and ovf on a STATUS read (sedrd_i low with a matching address), taking effect on the next edge.
REQ-022 SHALL implement FSM states IDLE, RUN, GAP and DONE.
REQ-023 SHALL, in IDLE, on start copy LEN to remaining and go to RUN; if LEN is 0, go directly to DONE.
REQ-024 SHALL, in RUN, assert out_vld_o whenever the FIFO is non-empty, with out_dat_o equal to the FIFO head, and hold both stable until out_rdy_i is high.
REQ-025 SHALL treat a beat as out_vld_o and out_rdy_i both high at a clock edge; each beat pops the head and decrements remaining.
REQ-026 SHALL, after a beat, go to DONE if remaining becomes 0, otherwise to GAP when GAP>0, otherwise stay in RUN.
REQ-027 SHALL hold out_vld_o low for exactly GAP cycles in GAP, then return to RUN.
REQ-028 SHALL, in DONE, set done and return to IDLE in the next cycle.
REQ-029 SHALL drive irq_o = done AND irq_en.
REQ-030 SHALL ignore start when the state is not IDLE.
REQ-031 SHALL make flush take priority over start and beats: empty the FIFO, clear remaining, force IDLE and deassert out_vld_o the next cycle; done is preserved.
REQ-032 SHALL let a push and a pop in the same cycle on a non-full FIFO both succeed, leaving level unchanged.
REQ-033 SHALL wrap FIFO pointers modulo DEPTH, with level range 0..DEPTH.
REQ-034 SHALL set busy to 1 in RUN and GAP.

Reset
REQ-035 SHALL, while rst_i is low, asynchronously clear the FIFO, staging, LEN, remaining, irq_en, done, ovf and the GAP counter, and force the FSM to IDLE.
REQ-036 SHALL hold out_vld_o=0, out_dat_o=0, irq_o=0 and pr_src_o high-Z during reset; a reset mid-transfer abandons the transfer with no further beats.

Verification
REQ-037 SHALL cover: push 3 words 'h11111111/'h22222222/'h33333333, LEN=3, start, out_rdy_i=1, GAP=1 -> 3 beats on cycles t, t+2, t+4, then done=1 and STATUS read = 'h0A0.
REQ-038 SHALL cover: push DEPTH+1 words -> last word dropped, STATUS = full|ovf|level=DEPTH; the next STATUS read returns ovf=1, and a following read returns ovf=0.
REQ-039 SHALL cover: out_rdy_i low for 5 cycles while valid -> out_dat_o stable, remaining unchanged, no pop.
REQ-040 SHALL cover: LEN=0, start -> done next cycle with zero beats; with irq_en=1, irq_o=1 until a STATUS read.
REQ-041 SHALL cover: flush mid-RUN with 4 words queued -> IDLE, level=0, out_vld_o=0, remaining=0.
REQ-042 SHALL cover: rst_i low during GAP -> all outputs reset; after release a start with LEN=1 and 1 pushed word yields exactly one beat.
